// File: rtl/anton_neopixel_regbank_mc_pkg.sv
// Shared definitions for the multi-channel NeoPixel register bank.
// Region codes, register offsets, delta entry field positions, lookup FSM states.
package anton_neopixel_regbank_mc_pkg;

    localparam int BUFFER_END_DEFAULT = 255;

    localparam logic [1:0] REGION_VIRT  = 2'b00;
    localparam logic [1:0] REGION_DELTA = 2'b01;
    localparam logic [1:0] REGION_RAW   = 2'b10;
    localparam logic [1:0] REGION_REGS  = 2'b11;

    localparam logic [3:0] OFF_MAX_LO    = 4'd0;
    localparam logic [3:0] OFF_MAX_HI    = 4'd1;
    localparam logic [3:0] OFF_CTRL      = 4'd2;
    localparam logic [3:0] OFF_STATE     = 4'd3;
    localparam logic [3:0] OFF_WIDTH_LO  = 4'd5;
    localparam logic [3:0] OFF_WIDTH_HI  = 4'd6;
    localparam logic [3:0] OFF_HEIGHT_LO = 4'd7;
    localparam logic [3:0] OFF_HEIGHT_HI = 4'd8;

    localparam int DELTA_CH_LSB   = 13;
    localparam int DELTA_SKIP_BIT = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT,
        ST_COMMIT,
        ST_RD_LOOKUP,
        ST_RD_WAIT
    } lookupState_t;

    // Bit order matches the offset-2 register layout.
    typedef struct packed {
        logic is32bit;
        logic loop;
        logic run;
        logic limit;
        logic init;
    } ctrlBits_t;

    function automatic int chBits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/anton_neopixel_regbank_mc_if.sv
// Byte-wide bus between the bus adapter (master) and the register bank (slave).
// busReady low means the slave is stalling and ignores strobes.
interface anton_neopixel_regbank_mc_if;
    logic [17:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite;
    logic        busRead;
    logic [7:0]  busDataOut;
    logic        busReady;

    modport master (
        output busAddr, busDataIn, busWrite, busRead,
        input  busDataOut, busReady
    );

    modport slave (
        input  busAddr, busDataIn, busWrite, busRead,
        output busDataOut, busReady
    );
endinterface

// File: rtl/anton_neopixel_regbank_mc_ctrl_channel.sv
// One channel's max/control registers and engine-event priority.
// Latency: updates one cycle after the write or event; no backpressure.
module anton_neopixel_ctrl_channel
    import anton_neopixel_regbank_mc_pkg::*;
(
    input  logic        busClk,
    input  logic        busReset,
    input  logic        maxLoWr,
    input  logic        maxHiWr,
    input  logic        ctrlWr,
    input  logic [7:0]  wrData,
    input  logic        streamSyncOf,
    input  logic        syncStart,
    input  logic        initSlowDone,
    output logic [12:0] regMax,
    output ctrlBits_t   ctrl,
    output logic        initSlow
);
    always_ff @(posedge busClk) begin
        if (busReset) begin
            regMax   <= '0;
            ctrl     <= '0;
            initSlow <= 1'b0;
        end else begin
            if (maxLoWr) regMax[7:0]  <= wrData;
            if (maxHiWr) regMax[12:8] <= wrData[4:0];

            // A bus write owns the whole control byte for this cycle.
            if (ctrlWr) begin
                ctrl <= ctrlBits_t'(wrData[4:0]);
            end else if (initSlowDone) begin
                ctrl.init <= 1'b0;
                initSlow  <= 1'b0;
            end else if (ctrl.init) begin
                ctrl.limit   <= 1'b0;
                ctrl.run     <= 1'b0;
                ctrl.loop    <= 1'b0;
                ctrl.is32bit <= 1'b0;
                initSlow     <= 1'b1;
            end else if (syncStart) begin
                ctrl.run <= 1'b1;
            end else if (streamSyncOf) begin
                ctrl.run <= ctrl.loop;
            end
        end
    end
endmodule

// File: rtl/anton_ram_2port_symmetric.sv
// Simple dual-port RAM: one write port, one registered read port, same width.
// Latency: read data one cycle after address; no backpressure, contents not reset.
module anton_ram_2port_symmetric #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 256
) (
    input  logic                 clk,
    input  logic                 wrEn,
    input  logic [ADDR_BITS-1:0] wrAddr,
    input  logic [DATA_BITS-1:0] wrData,
    input  logic [ADDR_BITS-1:0] rdAddr,
    output logic [DATA_BITS-1:0] rdData
);
    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        rdData <= mem[rdAddr];
    end
endmodule

// File: rtl/anton_neopixel_regbank_mc.sv
// Bus front end: per-channel control regs and raw RAMs, shared delta map, stalling virtual-write lookup.
// Latency: reads 1 cycle, virtual writes stall 3; ANTON_NEOPIXEL_DELTA_READBACK_EN adds 2-cycle delta reads.
// Backpressure: busReady is low whenever the lookup FSM is busy; strobes are ignored then.
module anton_neopixel_regbank_mc
    import anton_neopixel_regbank_mc_pkg::*;
#(
    parameter int  CHANNELS    = 2,
    parameter int  BUFFER_END  = BUFFER_END_DEFAULT,
    parameter int  VIRTUAL_END = BUFFER_END_DEFAULT,
    localparam int CH_BITS      = chBits(CHANNELS),
    localparam int BUFFER_BITS  = $clog2(BUFFER_END + 1),
    localparam int VIRTUAL_BITS = $clog2(VIRTUAL_END + 1)
) (
    input  logic                            busClk,
    input  logic                            busReset,
    anton_neopixel_regbank_mc_if.slave      bus,
    input  logic [CHANNELS*BUFFER_BITS-1:0] pixelIxComb,
    output logic [CHANNELS*8-1:0]           pixelByte,
    input  logic [CHANNELS-1:0]             streamSyncOf,
    input  logic [CHANNELS-1:0]             syncStart,
    input  logic [CHANNELS-1:0]             state,
    input  logic [CHANNELS-1:0]             initSlowDone,
    output logic [CHANNELS*13-1:0]          regMax,
    output logic [CHANNELS-1:0]             regCtrlInit,
    output logic [CHANNELS-1:0]             regCtrlLimit,
    output logic [CHANNELS-1:0]             regCtrlRun,
    output logic [CHANNELS-1:0]             regCtrlLoop,
    output logic [CHANNELS-1:0]             regCtrl32bit,
    output logic [CHANNELS-1:0]             initSlow,
    output logic [13:0]                     regWidth,
    output logic [13:0]                     regHeight
);
    logic [1:0]  region;
    logic [3:0]  regCh;
    logic [3:0]  regOff;
    logic        wrAcc, rdAcc, regWrAcc;
    logic        startVirt, startDeltaRd, rdFf;
    logic        busReadyInt, commitWr, deltaCapture;
    logic        deltaWr;
    logic [7:0]  deltaHold;
    logic [15:0] deltaDout;
    logic [7:0]  regRdData;
    logic [7:0]  dataOutQ;

    lookupState_t            curState, nextState;
    logic [VIRTUAL_BITS-1:0] lookupAddr;
    logic [7:0]              lookupData;
    logic                    lookupHiByte;

    logic [CH_BITS-1:0]      commitCh;
    logic [BUFFER_BITS-1:0]  commitIx;

    logic [12:0] chMax  [CHANNELS];
    ctrlBits_t   chCtrl [CHANNELS];

    logic unusedBits;

    assign region   = bus.busAddr[17:16];
    assign regCh    = bus.busAddr[7:4];
    assign regOff   = bus.busAddr[3:0];
    assign wrAcc    = bus.busWrite && busReadyInt;
    assign rdAcc    = bus.busRead && busReadyInt;
    assign regWrAcc = wrAcc && (region == REGION_REGS);

    assign startVirt = wrAcc && (region == REGION_VIRT);
`ifdef ANTON_NEOPIXEL_DELTA_READBACK_EN
    assign startDeltaRd = rdAcc && (region == REGION_DELTA) && !startVirt;
    assign rdFf         = rdAcc && (region != REGION_REGS) && (region != REGION_DELTA);
`else
    assign startDeltaRd = 1'b0;
    assign rdFf         = rdAcc && (region != REGION_REGS);
`endif

    assign commitCh = deltaDout[DELTA_CH_LSB +: CH_BITS];
    assign commitIx = deltaDout[BUFFER_BITS-1:0];

    // ---------------- lookup FSM ----------------
    always_ff @(posedge busClk) begin
        if (busReset) curState <= ST_IDLE;
        else          curState <= nextState;
    end

    always_comb begin
        nextState = curState;
        case (curState)
            ST_IDLE: begin
                if (startVirt)         nextState = ST_LOOKUP;
                else if (startDeltaRd) nextState = ST_RD_LOOKUP;
            end
            ST_LOOKUP:    nextState = ST_WAIT;
            ST_WAIT:      nextState = ST_COMMIT;
            ST_COMMIT:    nextState = ST_IDLE;
            ST_RD_LOOKUP: nextState = ST_RD_WAIT;
            ST_RD_WAIT:   nextState = ST_IDLE;
            default:      nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        busReadyInt  = 1'b0;
        commitWr     = 1'b0;
        deltaCapture = 1'b0;
        case (curState)
            ST_IDLE:    busReadyInt  = 1'b1;
            // A reset landing on the commit cycle must still suppress the write.
            ST_COMMIT:  commitWr     = !deltaDout[DELTA_SKIP_BIT] && !busReset;
            ST_RD_WAIT: deltaCapture = 1'b1;
            default: ;
        endcase
    end

    assign bus.busReady = busReadyInt;

    always_ff @(posedge busClk) begin
        if (busReset) begin
            lookupAddr   <= '0;
            lookupData   <= '0;
            lookupHiByte <= 1'b0;
        end else if (startVirt) begin
            lookupAddr <= bus.busAddr[VIRTUAL_BITS-1:0];
            lookupData <= bus.busDataIn;
        end else if (startDeltaRd) begin
            lookupAddr   <= bus.busAddr[VIRTUAL_BITS:1];
            lookupHiByte <= bus.busAddr[0];
        end
    end

    // ---------------- delta map ----------------
    assign deltaWr = wrAcc && (region == REGION_DELTA) && bus.busAddr[0];

    always_ff @(posedge busClk) begin
        if (busReset)                                                 deltaHold <= '0;
        else if (wrAcc && (region == REGION_DELTA) && !bus.busAddr[0]) deltaHold <= bus.busDataIn;
    end

    anton_ram_2port_symmetric #(
        .ADDR_BITS (VIRTUAL_BITS),
        .DATA_BITS (16),
        .DEPTH     (VIRTUAL_END + 1)
    ) uDeltaRam (
        .clk    (busClk),
        .wrEn   (deltaWr),
        .wrAddr (bus.busAddr[VIRTUAL_BITS:1]),
        .wrData ({bus.busDataIn, deltaHold}),
        .rdAddr (lookupAddr),
        .rdData (deltaDout)
    );

    // ---------------- per-channel slices ----------------
    for (genvar c = 0; c < CHANNELS; c++) begin : gCh
        localparam logic [1:0]         RAW_ID = 2'(c);
        localparam logic [3:0]         REG_ID = 4'(c);
        localparam logic [CH_BITS-1:0] CMT_ID = CH_BITS'(c);

        logic regSel, rawBusWr, commitHit;

        assign regSel    = regWrAcc && (regCh == REG_ID);
        assign rawBusWr  = wrAcc && (region == REGION_RAW) && (bus.busAddr[15:14] == RAW_ID);
        assign commitHit = commitWr && (commitCh == CMT_ID);

        anton_neopixel_ctrl_channel uCtrl (
            .busClk       (busClk),
            .busReset     (busReset),
            .maxLoWr      (regSel && (regOff == OFF_MAX_LO)),
            .maxHiWr      (regSel && (regOff == OFF_MAX_HI)),
            .ctrlWr       (regSel && (regOff == OFF_CTRL)),
            .wrData       (bus.busDataIn),
            .streamSyncOf (streamSyncOf[c]),
            .syncStart    (syncStart[c]),
            .initSlowDone (initSlowDone[c]),
            .regMax       (chMax[c]),
            .ctrl         (chCtrl[c]),
            .initSlow     (initSlow[c])
        );

        anton_ram_2port_symmetric #(
            .ADDR_BITS (BUFFER_BITS),
            .DATA_BITS (8),
            .DEPTH     (BUFFER_END + 1)
        ) uRawRam (
            .clk    (busClk),
            .wrEn   (rawBusWr || commitHit),
            .wrAddr (commitHit ? commitIx : bus.busAddr[BUFFER_BITS-1:0]),
            .wrData (commitHit ? lookupData : bus.busDataIn),
            .rdAddr (pixelIxComb[c*BUFFER_BITS +: BUFFER_BITS]),
            .rdData (pixelByte[c*8 +: 8])
        );

        assign regMax[c*13 +: 13] = chMax[c];
        assign regCtrlInit[c]     = chCtrl[c].init;
        assign regCtrlLimit[c]    = chCtrl[c].limit;
        assign regCtrlRun[c]      = chCtrl[c].run;
        assign regCtrlLoop[c]     = chCtrl[c].loop;
        assign regCtrl32bit[c]    = chCtrl[c].is32bit;
    end

    // ---------------- global geometry ----------------
    always_ff @(posedge busClk) begin
        if (busReset) begin
            regWidth  <= '0;
            regHeight <= '0;
        end else if (regWrAcc) begin
            case (regOff)
                OFF_WIDTH_LO:  regWidth[7:0]   <= bus.busDataIn;
                OFF_WIDTH_HI:  regWidth[13:8]  <= bus.busDataIn[5:0];
                OFF_HEIGHT_LO: regHeight[7:0]  <= bus.busDataIn;
                OFF_HEIGHT_HI: regHeight[13:8] <= bus.busDataIn[5:0];
                default: ;
            endcase
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        regRdData = '0;
        case (regOff)
            OFF_WIDTH_LO:  regRdData = regWidth[7:0];
            OFF_WIDTH_HI:  regRdData = {2'b00, regWidth[13:8]};
            OFF_HEIGHT_LO: regRdData = regHeight[7:0];
            OFF_HEIGHT_HI: regRdData = {2'b00, regHeight[13:8]};
            default: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (regCh == 4'(c)) begin
                        case (regOff)
                            OFF_MAX_LO: regRdData = chMax[c][7:0];
                            OFF_MAX_HI: regRdData = {3'b000, chMax[c][12:8]};
                            OFF_CTRL:   regRdData = {3'b000, chCtrl[c]};
                            OFF_STATE:  regRdData = {7'b0, state[c]};
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge busClk) begin
        if (busReset) begin
            dataOutQ <= '0;
        end else if (rdAcc && (region == REGION_REGS)) begin
            dataOutQ <= regRdData;
        end else if (rdFf) begin
            dataOutQ <= 8'hFF;
        end else if (deltaCapture) begin
            dataOutQ <= lookupHiByte ? deltaDout[15:8] : deltaDout[7:0];
        end
    end

    assign bus.busDataOut = dataOutQ;

    assign unusedBits = ^{bus.busAddr, deltaDout};
endmodule

// File: tb/tb_anton_neopixel_regbank_mc.sv
// Directed self-checking bench for anton_neopixel_regbank_mc (default parameters).
// Covers both builds of ANTON_NEOPIXEL_DELTA_READBACK_EN.
module tb_anton_neopixel_regbank_mc;
    import anton_neopixel_regbank_mc_pkg::*;

    localparam int CH = 2;
    localparam int BB = $clog2(BUFFER_END_DEFAULT + 1);

    logic              busClk = 1'b0;
    logic              busReset;
    logic [CH*BB-1:0]  pixelIxComb;
    logic [CH*8-1:0]   pixelByte;
    logic [CH-1:0]     streamSyncOf, syncStart, state, initSlowDone;
    logic [CH*13-1:0]  regMax;
    logic [CH-1:0]     regCtrlInit, regCtrlLimit, regCtrlRun, regCtrlLoop, regCtrl32bit, initSlow;
    logic [13:0]       regWidth, regHeight;

    int nCompared   = 0;
    int nMismatched = 0;

    anton_neopixel_regbank_mc_if bus ();

    anton_neopixel_regbank_mc #(.CHANNELS(CH)) dut (
        .busClk       (busClk),
        .busReset     (busReset),
        .bus          (bus),
        .pixelIxComb  (pixelIxComb),
        .pixelByte    (pixelByte),
        .streamSyncOf (streamSyncOf),
        .syncStart    (syncStart),
        .state        (state),
        .initSlowDone (initSlowDone),
        .regMax       (regMax),
        .regCtrlInit  (regCtrlInit),
        .regCtrlLimit (regCtrlLimit),
        .regCtrlRun   (regCtrlRun),
        .regCtrlLoop  (regCtrlLoop),
        .regCtrl32bit (regCtrl32bit),
        .initSlow     (initSlow),
        .regWidth     (regWidth),
        .regHeight    (regHeight)
    );

    always #5 busClk = ~busClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [17:0] regAddr(input logic [3:0] ch, input logic [3:0] off);
        return {2'b11, 8'h00, ch, off};
    endfunction
    function automatic logic [17:0] rawAddr(input logic [1:0] ch, input logic [13:0] ix);
        return {2'b10, ch, ix};
    endfunction
    function automatic logic [17:0] deltaAddr(input logic [15:0] a);
        return {2'b01, a};
    endfunction
    function automatic logic [17:0] virtAddr(input logic [15:0] a);
        return {2'b00, a};
    endfunction

    task automatic tick();
        @(posedge busClk);
        #1;
    endtask

    task automatic busWr(input logic [17:0] a, input logic [7:0] d);
        bus.busAddr   = a;
        bus.busDataIn = d;
        bus.busWrite  = 1'b1;
        tick();
        bus.busWrite  = 1'b0;
    endtask

    task automatic busRd(input logic [17:0] a);
        bus.busAddr = a;
        bus.busRead = 1'b1;
        tick();
        bus.busRead = 1'b0;
    endtask

    task automatic waitReady(output int stalls);
        stalls = 0;
        while (bus.busReady !== 1'b1 && stalls < 20) begin
            stalls++;
            tick();
        end
    endtask

    task automatic readPixel(input int ch, input logic [BB-1:0] ix, output logic [7:0] v);
        pixelIxComb[ch*BB +: BB] = ix;
        tick();
        v = pixelByte[ch*8 +: 8];
    endtask

    task automatic test_reset();
        bus.busAddr = '0; bus.busDataIn = '0; bus.busWrite = 1'b0; bus.busRead = 1'b0;
        pixelIxComb = '0; streamSyncOf = '0; syncStart = '0; state = '0; initSlowDone = '0;
        busReset = 1'b1;
        repeat (3) tick();
        busReset = 1'b0;
        nCompared++; if (bus.busReady !== 1'b1) begin nMismatched++; $display("FAIL reset_ready: got %b want 1", bus.busReady); end
        nCompared++; if (bus.busDataOut !== 8'h00) begin nMismatched++; $display("FAIL reset_dout: got %h want 00", bus.busDataOut); end
        nCompared++; if ({regCtrlInit, regCtrlLimit, regCtrlRun, regCtrlLoop, regCtrl32bit, initSlow} !== '0) begin nMismatched++; $display("FAIL reset_ctrl: got %b want 0", {regCtrlInit, regCtrlLimit, regCtrlRun, regCtrlLoop, regCtrl32bit, initSlow}); end
        nCompared++; if ({regMax, regWidth, regHeight} !== '0) begin nMismatched++; $display("FAIL reset_geom: got %h want 0", {regMax, regWidth, regHeight}); end
        busRd(rawAddr(2'd0, 14'd0));
        nCompared++; if (bus.busDataOut !== 8'hFF) begin nMismatched++; $display("FAIL raw_read_ff: got %h want ff", bus.busDataOut); end
        busRd(regAddr(4'd1, 4'd2));
        nCompared++; if (bus.busDataOut !== 8'h00) begin nMismatched++; $display("FAIL ctrl1_read_reset: got %h want 00", bus.busDataOut); end
        nCompared++; if (bus.busReady !== 1'b1) begin nMismatched++; $display("FAIL reg_read_nostall: got %b want 1", bus.busReady); end
    endtask

    task automatic test_registers();
        busWr(regAddr(4'd1, 4'd0), 8'hAB);
        busWr(regAddr(4'd1, 4'd1), 8'hFF);
        nCompared++; if (regMax[25:13] !== 13'h1FAB) begin nMismatched++; $display("FAIL max1: got %h want 1fab", regMax[25:13]); end
        nCompared++; if (regMax[12:0] !== 13'h0) begin nMismatched++; $display("FAIL max0_untouched: got %h want 0", regMax[12:0]); end
        busRd(regAddr(4'd1, 4'd1));
        nCompared++; if (bus.busDataOut !== 8'h1F) begin nMismatched++; $display("FAIL max1_hi_read: got %h want 1f", bus.busDataOut); end
        busWr(regAddr(4'd3, 4'd5), 8'h34);
        busWr(regAddr(4'd0, 4'd6), 8'hFF);
        nCompared++; if (regWidth !== 14'h3F34) begin nMismatched++; $display("FAIL width: got %h want 3f34", regWidth); end
        busRd(regAddr(4'd2, 4'd6));
        nCompared++; if (bus.busDataOut !== 8'h3F) begin nMismatched++; $display("FAIL width_hi_read: got %h want 3f", bus.busDataOut); end
        busWr(regAddr(4'd0, 4'd7), 8'h12);
        busWr(regAddr(4'd0, 4'd8), 8'hC5);
        nCompared++; if (regHeight !== 14'h0512) begin nMismatched++; $display("FAIL height: got %h want 0512", regHeight); end
        state = 2'b10;
        busRd(regAddr(4'd1, 4'd3));
        nCompared++; if (bus.busDataOut !== 8'h01) begin nMismatched++; $display("FAIL state1_read: got %h want 01", bus.busDataOut); end
        busRd(regAddr(4'd0, 4'd3));
        nCompared++; if (bus.busDataOut !== 8'h00) begin nMismatched++; $display("FAIL state0_read: got %h want 00", bus.busDataOut); end
        state = 2'b00;
        busWr(regAddr(4'd1, 4'd4), 8'h77);
        busRd(rawAddr(2'd1, 14'd0));
        busRd(regAddr(4'd1, 4'd4));
        nCompared++; if (bus.busDataOut !== 8'h00) begin nMismatched++; $display("FAIL unmapped_read: got %h want 00", bus.busDataOut); end
        busWr(regAddr(4'd2, 4'd0), 8'h55);
        nCompared++; if (regMax !== {13'h1FAB, 13'h0}) begin nMismatched++; $display("FAIL bad_channel_write: got %h want %h", regMax, {13'h1FAB, 13'h0}); end
        busRd(rawAddr(2'd0, 14'd0));
        busRd(regAddr(4'd2, 4'd0));
        nCompared++; if (bus.busDataOut !== 8'h00) begin nMismatched++; $display("FAIL bad_channel_read: got %h want 00", bus.busDataOut); end
    endtask

    task automatic test_virtual_write();
        int stalls;
        logic [7:0] v;
        busWr(rawAddr(2'd0, 14'd3), 8'h3C);
        busWr(rawAddr(2'd1, 14'd3), 8'h00);
        busWr(deltaAddr(16'd10), 8'h03);
        busWr(deltaAddr(16'd11), 8'h20);
        busWr(virtAddr(16'd5), 8'hA5);
        waitReady(stalls);
        nCompared++; if (stalls != 3) begin nMismatched++; $display("FAIL virt_stalls: got %0d want 3", stalls); end
        readPixel(1, 8'd3, v);
        nCompared++; if (v !== 8'hA5) begin nMismatched++; $display("FAIL virt_ch1_ix3: got %h want a5", v); end
        readPixel(0, 8'd3, v);
        nCompared++; if (v !== 8'h3C) begin nMismatched++; $display("FAIL virt_ch0_ix3_kept: got %h want 3c", v); end
    endtask

    task automatic test_skip_and_stall();
        int stalls;
        logic [7:0] v;
        busWr(rawAddr(2'd0, 14'd0), 8'h77);
        busWr(rawAddr(2'd1, 14'd0), 8'h66);
        busWr(rawAddr(2'd0, 14'd5), 8'h00);
        busWr(deltaAddr(16'd12), 8'h00);
        busWr(deltaAddr(16'd13), 8'h80);
        busWr(virtAddr(16'd6), 8'h11);
        // a raw write held during the stall must be ignored
        bus.busAddr = rawAddr(2'd0, 14'd5); bus.busDataIn = 8'hEE; bus.busWrite = 1'b1;
        waitReady(stalls);
        bus.busWrite = 1'b0;
        nCompared++; if (stalls != 3) begin nMismatched++; $display("FAIL skip_stalls: got %0d want 3", stalls); end
        readPixel(0, 8'd0, v);
        nCompared++; if (v !== 8'h77) begin nMismatched++; $display("FAIL skip_ch0_ix0: got %h want 77", v); end
        readPixel(1, 8'd0, v);
        nCompared++; if (v !== 8'h66) begin nMismatched++; $display("FAIL skip_ch1_ix0: got %h want 66", v); end
        readPixel(0, 8'd5, v);
        nCompared++; if (v !== 8'h00) begin nMismatched++; $display("FAIL stalled_write_ignored: got %h want 00", v); end
    endtask

    task automatic test_ctrl_init();
        busWr(regAddr(4'd0, 4'd2), 8'h1E);
        nCompared++; if ({regCtrl32bit[0], regCtrlLoop[0], regCtrlRun[0], regCtrlLimit[0], regCtrlInit[0]} !== 5'b11110) begin nMismatched++; $display("FAIL ctrl0_1e: got %b want 11110", {regCtrl32bit[0], regCtrlLoop[0], regCtrlRun[0], regCtrlLimit[0], regCtrlInit[0]}); end
        busWr(regAddr(4'd0, 4'd2), 8'h01);
        tick();
        nCompared++; if ({regCtrl32bit[0], regCtrlLoop[0], regCtrlRun[0], regCtrlLimit[0], regCtrlInit[0], initSlow[0]} !== 6'b000011) begin nMismatched++; $display("FAIL ctrl0_init: got %b want 000011", {regCtrl32bit[0], regCtrlLoop[0], regCtrlRun[0], regCtrlLimit[0], regCtrlInit[0], initSlow[0]}); end
        busRd(regAddr(4'd0, 4'd2));
        nCompared++; if (bus.busDataOut !== 8'h01) begin nMismatched++; $display("FAIL ctrl0_read: got %h want 01", bus.busDataOut); end
        initSlowDone = 2'b01;
        tick();
        initSlowDone = 2'b00;
        nCompared++; if ({regCtrlInit[0], initSlow[0]} !== 2'b00) begin nMismatched++; $display("FAIL init_slow_done: got %b want 00", {regCtrlInit[0], initSlow[0]}); end
    endtask

    task automatic test_ctrl_priority();
        busWr(regAddr(4'd1, 4'd2), 8'h00);
        syncStart = 2'b10; streamSyncOf = 2'b10;
        tick();
        syncStart = 2'b00; streamSyncOf = 2'b00;
        nCompared++; if (regCtrlRun[1] !== 1'b1) begin nMismatched++; $display("FAIL sync_over_of: got %b want 1", regCtrlRun[1]); end
        streamSyncOf = 2'b10;
        tick();
        streamSyncOf = 2'b00;
        nCompared++; if (regCtrlRun[1] !== 1'b0) begin nMismatched++; $display("FAIL of_noloop: got %b want 0", regCtrlRun[1]); end
        busWr(regAddr(4'd1, 4'd2), 8'h08);
        streamSyncOf = 2'b10;
        tick();
        streamSyncOf = 2'b00;
        nCompared++; if (regCtrlRun[1] !== 1'b1) begin nMismatched++; $display("FAIL of_loop: got %b want 1", regCtrlRun[1]); end
        syncStart = 2'b10; streamSyncOf = 2'b10;
        busWr(regAddr(4'd1, 4'd2), 8'h00);
        syncStart = 2'b00; streamSyncOf = 2'b00;
        nCompared++; if ({regCtrlRun[1], regCtrlLoop[1]} !== 2'b00) begin nMismatched++; $display("FAIL bus_over_sync: got %b want 00", {regCtrlRun[1], regCtrlLoop[1]}); end
        nCompared++; if (regCtrlRun[0] !== 1'b0) begin nMismatched++; $display("FAIL ch0_run_isolated: got %b want 0", regCtrlRun[0]); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] v;
        busWr(rawAddr(2'd1, 14'd3), 8'h00);
        busWr(virtAddr(16'd5), 8'h5A);
        tick();
        busReset = 1'b1;
        tick();
        busReset = 1'b0;
        nCompared++; if (bus.busReady !== 1'b1) begin nMismatched++; $display("FAIL abort_ready: got %b want 1", bus.busReady); end
        tick();
        tick();
        nCompared++; if (bus.busReady !== 1'b1) begin nMismatched++; $display("FAIL abort_idle: got %b want 1", bus.busReady); end
        readPixel(1, 8'd3, v);
        nCompared++; if (v !== 8'h00) begin nMismatched++; $display("FAIL abort_no_write: got %h want 00", v); end
    endtask

    task automatic test_delta_read();
        int stalls;
`ifdef ANTON_NEOPIXEL_DELTA_READBACK_EN
        busRd(deltaAddr(16'd11));
        waitReady(stalls);
        nCompared++; if (stalls != 2) begin nMismatched++; $display("FAIL delta_rd_stalls: got %0d want 2", stalls); end
        nCompared++; if (bus.busDataOut !== 8'h20) begin nMismatched++; $display("FAIL delta_rd_hi: got %h want 20", bus.busDataOut); end
        busRd(deltaAddr(16'd10));
        waitReady(stalls);
        nCompared++; if (bus.busDataOut !== 8'h03) begin nMismatched++; $display("FAIL delta_rd_lo: got %h want 03", bus.busDataOut); end
`else
        busRd(regAddr(4'd1, 4'd2));
        busRd(deltaAddr(16'd11));
        stalls = 0;
        nCompared++; if (bus.busReady !== 1'b1) begin nMismatched++; $display("FAIL delta_rd_nostall: got %b want 1 (stalls %0d)", bus.busReady, stalls); end
        nCompared++; if (bus.busDataOut !== 8'hFF) begin nMismatched++; $display("FAIL delta_rd_ff: got %h want ff", bus.busDataOut); end
`endif
    endtask

    initial begin
        test_reset();
        test_registers();
        test_virtual_write();
        test_skip_and_stall();
        test_ctrl_init();
        test_ctrl_priority();
        test_reset_abort();
        test_delta_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
